// File: rtl/video_dram_sched_if.sv
// Bundle of the scheduler's slot strobe, requester and DRAM-side signals.
// The slave modport is the scheduler view. The master modport is the requester/controller view.
interface video_dram_sched_if;
  logic        dram_stb;
  logic        video_go;
  logic [4:0]  video_bw;
  logic [20:0] video_addr;
  logic        cpu_req;
  logic        cpu_rnw;
  logic [20:0] cpu_addr;
  logic        dma_req;
  logic        dma_rnw;
  logic [20:0] dma_addr;
  logic        dram_req;
  logic        dram_rnw;
  logic [20:0] dram_addr;
  logic        video_next;
  logic        cpu_next;
  logic        dma_next;
  logic        video_slot;

  modport slave (
    input  dram_stb, video_go, video_bw, video_addr,
    input  cpu_req, cpu_rnw, cpu_addr,
    input  dma_req, dma_rnw, dma_addr,
    output dram_req, dram_rnw, dram_addr,
    output video_next, cpu_next, dma_next, video_slot
  );

  modport master (
    output dram_stb, video_go, video_bw, video_addr,
    output cpu_req, cpu_rnw, cpu_addr,
    output dma_req, dma_rnw, dma_addr,
    input  dram_req, dram_rnw, dram_addr,
    input  video_next, cpu_next, dma_next, video_slot
  );
endinterface

// File: rtl/video_dram_sched.sv
// DRAM slot scheduler: reserved video slots per window, remaining slots go to CPU, then DMA.
// Optional DMA_STARVE_GUARD_EN: a DMA slot is forced after STARVE_LIM consecutive DMA denials.
module video_dram_sched #(
  parameter int STARVE_LIM = 16
) (
  input  logic               clk,
  input  logic               rst,
  video_dram_sched_if.slave  bus
);

  typedef enum logic [1:0] {GNT_IDLE, GNT_VID, GNT_CPU, GNT_DMA} gnt_e;

  logic [2:0] r_cnt;
  logic [2:0] w_mask;
  logic [2:0] w_need;
  logic       w_rsv;
  logic       w_force_dma;
  gnt_e       w_gnt;

  assign w_mask = {bus.video_bw[4], bus.video_bw[3], 1'b1};
  assign w_rsv  = bus.video_go && (r_cnt < w_need);

  // Decode the one-hot need field; an all-zero code reserves nothing
  always_comb begin
    w_need = 3'd0;
    if (bus.video_bw[2]) begin
      w_need = 3'd4;
    end else if (bus.video_bw[1]) begin
      w_need = 3'd2;
    end else if (bus.video_bw[0]) begin
      w_need = 3'd1;
    end else begin
      w_need = 3'd0;
    end
  end

`ifdef DMA_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIM + 1);
  logic [SW-1:0] r_starve;

  assign w_force_dma = (r_starve == SW'(STARVE_LIM));

  // Count consecutive DMA denials; saturates at the limit until a DMA grant clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
    end else if (bus.dram_stb) begin
      if (!bus.dma_req || (w_gnt == GNT_DMA)) begin
        r_starve <= '0;
      end else if (r_starve != SW'(STARVE_LIM)) begin
        r_starve <= r_starve + SW'(1);
      end else begin
        r_starve <= r_starve;
      end
    end else begin
      r_starve <= r_starve;
    end
  end
`else
  assign w_force_dma = 1'b0;
`endif

  // Slot owner: video reservation first, then CPU over DMA unless starvation forces DMA
  always_comb begin
    w_gnt = GNT_IDLE;
    if (w_rsv) begin
      w_gnt = GNT_VID;
    end else if (w_force_dma && bus.dma_req) begin
      w_gnt = GNT_DMA;
    end else if (bus.cpu_req) begin
      w_gnt = GNT_CPU;
    end else if (bus.dma_req) begin
      w_gnt = GNT_DMA;
    end else begin
      w_gnt = GNT_IDLE;
    end
  end

  // Window position; masked wrap test keeps a mid-window bw change from locking up
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 3'd0;
    end else if (bus.dram_stb) begin
      if (!bus.video_go) begin
        r_cnt <= 3'd0;
      end else if ((r_cnt & w_mask) == w_mask) begin
        r_cnt <= 3'd0;
      end else begin
        r_cnt <= r_cnt + 3'd1;
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Register the transaction for the slot; the next pulses last one clock
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.dram_req   <= 1'b0;
      bus.dram_rnw   <= 1'b1;
      bus.dram_addr  <= 21'd0;
      bus.video_next <= 1'b0;
      bus.cpu_next   <= 1'b0;
      bus.dma_next   <= 1'b0;
      bus.video_slot <= 1'b0;
    end else if (bus.dram_stb) begin
      bus.video_slot <= w_rsv;
      case (w_gnt)
        GNT_VID: begin
          bus.dram_req   <= 1'b1;
          bus.dram_rnw   <= 1'b1;
          bus.dram_addr  <= bus.video_addr;
          bus.video_next <= 1'b1;
          bus.cpu_next   <= 1'b0;
          bus.dma_next   <= 1'b0;
        end
        GNT_CPU: begin
          bus.dram_req   <= 1'b1;
          bus.dram_rnw   <= bus.cpu_rnw;
          bus.dram_addr  <= bus.cpu_addr;
          bus.video_next <= 1'b0;
          bus.cpu_next   <= 1'b1;
          bus.dma_next   <= 1'b0;
        end
        GNT_DMA: begin
          bus.dram_req   <= 1'b1;
          bus.dram_rnw   <= bus.dma_rnw;
          bus.dram_addr  <= bus.dma_addr;
          bus.video_next <= 1'b0;
          bus.cpu_next   <= 1'b0;
          bus.dma_next   <= 1'b1;
        end
        default: begin
          bus.dram_req   <= 1'b0;
          bus.dram_rnw   <= bus.dram_rnw;
          bus.dram_addr  <= bus.dram_addr;
          bus.video_next <= 1'b0;
          bus.cpu_next   <= 1'b0;
          bus.dma_next   <= 1'b0;
        end
      endcase
    end else begin
      bus.dram_req   <= bus.dram_req;
      bus.dram_rnw   <= bus.dram_rnw;
      bus.dram_addr  <= bus.dram_addr;
      bus.video_next <= 1'b0;
      bus.cpu_next   <= 1'b0;
      bus.dma_next   <= 1'b0;
      bus.video_slot <= bus.video_slot;
    end
  end

endmodule

// File: tb/tb_video_dram_sched.sv
// Directed bench for video_dram_sched: table of per-slot vectors plus reset and starvation sequences.
module tb_video_dram_sched;

  localparam logic [1:0] E_IDLE = 2'd0;
  localparam logic [1:0] E_VID  = 2'd1;
  localparam logic [1:0] E_CPU  = 2'd2;
  localparam logic [1:0] E_DMA  = 2'd3;

  localparam logic [20:0] CPU_ADDR = 21'h0_0AAA;
  localparam logic [20:0] DMA_ADDR = 21'h0_0555;

  typedef struct {
    logic       go;
    logic [4:0] bw;
    logic       cpu;
    logic       dma;
    logic [1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  vec_t vecs[$];

  video_dram_sched_if bus ();

  video_dram_sched #(.STARVE_LIM(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // One DRAM slot: strobe for a clock, check registered outputs, then check the gap cycle.
  task automatic run_slot(input logic go, input logic [4:0] bw, input logic cpu,
                          input logic dma, input logic [1:0] e, input int idx);
    logic [20:0] vaddr;
    logic [20:0] eaddr;
    logic        ernw;
    string       tag;
    vaddr = 21'h10_0000 + 21'(idx);
    tag = $sformatf("slot%0d", idx);
    @(negedge clk);
    bus.video_go   = go;
    bus.video_bw   = bw;
    bus.video_addr = vaddr;
    bus.cpu_req    = cpu;
    bus.dma_req    = dma;
    bus.dram_stb   = 1'b1;
    @(negedge clk);
    bus.dram_stb = 1'b0;
    chk({tag, "_req"}, 32'(bus.dram_req), 32'(e != E_IDLE));
    chk({tag, "_next"}, 32'({bus.video_next, bus.cpu_next, bus.dma_next}),
        32'({e == E_VID, e == E_CPU, e == E_DMA}));
    chk({tag, "_vslot"}, 32'(bus.video_slot), 32'(e == E_VID));
    if (e != E_IDLE) begin
      eaddr = (e == E_VID) ? vaddr : ((e == E_CPU) ? CPU_ADDR : DMA_ADDR);
      ernw  = (e == E_CPU) ? 1'b0 : 1'b1;
      chk({tag, "_addr"}, 32'(bus.dram_addr), 32'(eaddr));
      chk({tag, "_rnw"}, 32'(bus.dram_rnw), 32'(ernw));
    end
    @(negedge clk);
    chk({tag, "_gap_next"}, 32'({bus.video_next, bus.cpu_next, bus.dma_next}), 32'd0);
    chk({tag, "_gap_req"}, 32'(bus.dram_req), 32'(e != E_IDLE));
  endtask

  task automatic add(input logic go, input logic [4:0] bw, input logic cpu,
                     input logic dma, input logic [1:0] e);
    vec_t v;
    v.go = go; v.bw = bw; v.cpu = cpu; v.dma = dma; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    // 1 of 8: video then seven CPU slots, then video again
    add(1'b1, 5'b11001, 1'b1, 1'b0, E_VID);
    for (int i = 0; i < 7; i++) add(1'b1, 5'b11001, 1'b1, 1'b0, E_CPU);
    add(1'b1, 5'b11001, 1'b1, 1'b0, E_VID);
    // 4 of 2: every slot video despite CPU
    for (int i = 0; i < 3; i++) add(1'b1, 5'b00100, 1'b1, 1'b0, E_VID);
    // 1 of 4 with DMA only
    add(1'b1, 5'b01001, 1'b0, 1'b1, E_VID);
    for (int i = 0; i < 3; i++) add(1'b1, 5'b01001, 1'b0, 1'b1, E_DMA);
    add(1'b1, 5'b01001, 1'b0, 1'b1, E_VID);
    add(1'b1, 5'b01001, 1'b0, 1'b1, E_DMA);
    // video_go dropped mid-window, then reasserted
    for (int i = 0; i < 3; i++) add(1'b0, 5'b01001, 1'b0, 1'b1, E_DMA);
    add(1'b1, 5'b01001, 1'b0, 1'b1, E_VID);
    add(1'b1, 5'b01001, 1'b0, 1'b1, E_DMA);
    // bw change at cnt=5: wraps then V/C alternates
    add(1'b0, 5'b11001, 1'b1, 1'b0, E_CPU);
    add(1'b1, 5'b11001, 1'b1, 1'b0, E_VID);
    for (int i = 0; i < 4; i++) add(1'b1, 5'b11001, 1'b1, 1'b0, E_CPU);
    add(1'b1, 5'b00001, 1'b1, 1'b0, E_CPU);
    add(1'b1, 5'b00001, 1'b1, 1'b0, E_VID);
    add(1'b1, 5'b00001, 1'b1, 1'b0, E_CPU);
    add(1'b1, 5'b00001, 1'b1, 1'b0, E_VID);
    add(1'b1, 5'b00001, 1'b1, 1'b0, E_CPU);
    // Nothing requested
    add(1'b0, 5'b00001, 1'b0, 1'b0, E_IDLE);

    bus.dram_stb   = 1'b1;
    bus.video_go   = 1'b1;
    bus.video_bw   = 5'b11001;
    bus.video_addr = 21'h1F_FFFF;
    bus.cpu_req    = 1'b1;
    bus.cpu_rnw    = 1'b0;
    bus.cpu_addr   = CPU_ADDR;
    bus.dma_req    = 1'b1;
    bus.dma_rnw    = 1'b1;
    bus.dma_addr   = DMA_ADDR;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(bus.dram_req), 32'd0);
    chk("rst_next", 32'({bus.video_next, bus.cpu_next, bus.dma_next}), 32'd0);
    chk("rst_vslot", 32'(bus.video_slot), 32'd0);
    chk("rst_rnw", 32'(bus.dram_rnw), 32'd1);
    chk("rst_addr", 32'(bus.dram_addr), 32'd0);
    bus.dram_stb = 1'b0;
    bus.dma_req  = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_slot(vecs[i].go, vecs[i].bw, vecs[i].cpu, vecs[i].dma, vecs[i].exp, i);
    end

    // CPU and DMA both requesting with video off: DMA starves unless the guard is built in
    for (int s = 1; s <= 18; s++) begin
      logic [1:0] e;
      e = E_CPU;
`ifdef DMA_STARVE_GUARD_EN
      if (s == 17) e = E_DMA;
`endif
      run_slot(1'b0, 5'b11001, 1'b1, 1'b1, e, 100 + s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
